// File: rtl/param_cache.sv
// Direct-mapped data cache with multi-word lines between the CPU data port and
// data memory. Supports write-back/write-allocate or write-through/no-allocate
// operation, burst refill and eviction, and an uncached bypass path.
module param_cache #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int INDEX_W    = 6,
  parameter int OFFS_W     = 2,
  parameter int WRITE_BACK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_strobe,
  input  logic              cpu_RW,
  input  logic              uncached,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data_out,
  output logic [DATA_W-1:0] cpu_data_in,
  output logic              cpu_ready,
  output logic              mem_strobe,
  output logic              mem_RW,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFS_W;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFS_W - 2;
  // A zero-width counter is not legal, so keep one bit that always stays 0.
  localparam int CNT_W = (OFFS_W > 0) ? OFFS_W : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);
  localparam bit WB = (WRITE_BACK != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBACK  = 2'd1,
    FILL   = 2'd2,
    SINGLE = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [LINES-1:0]   valid_r;
  logic [LINES-1:0]   dirty_r;
  logic [TAG_W-1:0]   tag_r  [LINES];
  logic [DATA_W-1:0]  data_r [LINES][WORDS];

  logic [CNT_W-1:0]   word_s;
  logic [INDEX_W-1:0] index_s;
  logic [TAG_W-1:0]   tag_s;
  logic               hit_s;
  logic [DATA_W-1:0]  cached_word_s;
  logic [DATA_W-1:0]  victim_word_s;

  logic               cnt_inc_s;
  logic               cnt_clr_s;
  logic               fill_we_s;
  logic               fill_done_s;
  logic               word_we_s;
  logic               set_dirty_s;
  logic               clr_dirty_s;

  // Assemble a word-aligned line address from tag, index and word counter.
  function automatic logic [ADDR_W-1:0] line_addr(
    input logic [TAG_W-1:0]   t,
    input logic [INDEX_W-1:0] i,
    input logic [CNT_W-1:0]   c
  );
    return (ADDR_W'(t) << (INDEX_W + OFFS_W + 2)) |
           (ADDR_W'(i) << (OFFS_W + 2)) |
           (ADDR_W'(c & LAST_CNT) << 2);
  endfunction

  assign word_s        = CNT_W'(cpu_addr >> 2) & LAST_CNT;
  assign index_s       = INDEX_W'(cpu_addr >> (OFFS_W + 2));
  assign tag_s         = TAG_W'(cpu_addr >> (OFFS_W + INDEX_W + 2));
  assign cached_word_s = data_r[index_s][word_s];
  assign victim_word_s = data_r[index_s][cnt_r];
  assign hit_s         = cpu_strobe & ~uncached & valid_r[index_s] &
                         (tag_r[index_s] == tag_s);

  // Next-state, bus outputs and storage update strobes.
  always_comb begin
    state_s     = state_r;
    cpu_ready   = 1'b0;
    cpu_data_in = {DATA_W{1'b0}};
    mem_strobe  = 1'b0;
    mem_RW      = 1'b0;
    mem_addr    = {ADDR_W{1'b0}};
    mem_data_in = {DATA_W{1'b0}};
    busy        = (state_r != IDLE);
    cnt_inc_s   = 1'b0;
    cnt_clr_s   = 1'b0;
    fill_we_s   = 1'b0;
    fill_done_s = 1'b0;
    word_we_s   = 1'b0;
    set_dirty_s = 1'b0;
    clr_dirty_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_strobe) begin
          if (uncached) begin
            state_s = SINGLE;
          end else if (cpu_RW && !WB) begin
            state_s = SINGLE;
          end else if (hit_s) begin
            cpu_ready   = 1'b1;
            cpu_data_in = cached_word_s;
            if (cpu_RW) begin
              word_we_s   = 1'b1;
              set_dirty_s = 1'b1;
            end else begin
              word_we_s   = 1'b0;
            end
          end else if (WB && valid_r[index_s] && dirty_r[index_s]) begin
            state_s = WBACK;
          end else begin
            state_s = FILL;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WBACK: begin
        mem_strobe  = 1'b1;
        mem_RW      = 1'b1;
        mem_addr    = line_addr(tag_r[index_s], index_s, cnt_r);
        mem_data_in = victim_word_s;
        if (mem_ready) begin
          if (cnt_r == LAST_CNT) begin
            cnt_clr_s   = 1'b1;
            clr_dirty_s = 1'b1;
            state_s     = FILL;
          end else begin
            cnt_inc_s   = 1'b1;
          end
        end else begin
          cnt_inc_s = 1'b0;
        end
      end
      FILL: begin
        mem_strobe = 1'b1;
        mem_RW     = 1'b0;
        mem_addr   = line_addr(tag_s, index_s, cnt_r);
        if (mem_ready) begin
          fill_we_s = 1'b1;
          if (cnt_r == LAST_CNT) begin
            cnt_clr_s   = 1'b1;
            fill_done_s = 1'b1;
            state_s     = IDLE;
          end else begin
            cnt_inc_s   = 1'b1;
          end
        end else begin
          fill_we_s = 1'b0;
        end
      end
      SINGLE: begin
        mem_strobe  = 1'b1;
        mem_RW      = cpu_RW;
        mem_addr    = cpu_addr & ~ADDR_W'(3);
        mem_data_in = cpu_data_out;
        if (mem_ready) begin
          cpu_ready   = cpu_strobe;
          cpu_data_in = mem_data_out;
          state_s     = IDLE;
          // Keep a resident line coherent with a write-through store.
          if (cpu_RW && hit_s) begin
            word_we_s = 1'b1;
          end else begin
            word_we_s = 1'b0;
          end
        end else begin
          state_s = SINGLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, burst counter and per-line valid/dirty bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      valid_r <= {LINES{1'b0}};
      dirty_r <= {LINES{1'b0}};
    end else begin
      state_r <= state_s;
      if (cnt_clr_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (fill_done_s) begin
        valid_r[index_s] <= 1'b1;
        dirty_r[index_s] <= 1'b0;
      end else if (clr_dirty_s) begin
        dirty_r[index_s] <= 1'b0;
      end else if (set_dirty_s) begin
        dirty_r[index_s] <= 1'b1;
      end else begin
        dirty_r <= dirty_r;
      end
    end
  end

  // Line data and tag storage; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && fill_we_s) begin
      data_r[index_s][cnt_r] <= mem_data_out;
    end else if (reset && word_we_s) begin
      data_r[index_s][word_s] <= cpu_data_out;
    end else begin
      data_r[index_s][word_s] <= data_r[index_s][word_s];
    end
    if (reset && fill_done_s) begin
      tag_r[index_s] <= tag_s;
    end else begin
      tag_r[index_s] <= tag_r[index_s];
    end
  end

endmodule

// File: tb/tb_param_cache.sv
// Directed bench for param_cache: one write-back instance and one
// write-through instance share the CPU stimulus, selected by sel.
module tb_param_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        cpu_strobe;
  logic        cpu_RW;
  logic        uncached;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data_out;
  logic [31:0] mem_data_out;
  logic        mem_ready;

  logic [31:0] a_cpu_data_in, b_cpu_data_in, a_mem_addr, b_mem_addr;
  logic [31:0] a_mem_data_in, b_mem_data_in;
  logic        a_cpu_ready, b_cpu_ready, a_mem_strobe, b_mem_strobe;
  logic        a_mem_RW, b_mem_RW, a_busy, b_busy;
  logic        a_strobe, b_strobe, a_mem_ready, b_mem_ready;

  logic [31:0] cpu_data_in, mem_addr, mem_data_in;
  logic        cpu_ready, mem_strobe, mem_RW, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign a_strobe    = cpu_strobe & ~sel;
  assign b_strobe    = cpu_strobe & sel;
  assign a_mem_ready = mem_ready & ~sel;
  assign b_mem_ready = mem_ready & sel;

  assign cpu_data_in = sel ? b_cpu_data_in : a_cpu_data_in;
  assign cpu_ready   = sel ? b_cpu_ready   : a_cpu_ready;
  assign mem_strobe  = sel ? b_mem_strobe  : a_mem_strobe;
  assign mem_RW      = sel ? b_mem_RW      : a_mem_RW;
  assign mem_addr    = sel ? b_mem_addr    : a_mem_addr;
  assign mem_data_in = sel ? b_mem_data_in : a_mem_data_in;
  assign busy        = sel ? b_busy        : a_busy;

  param_cache #(.WRITE_BACK(1)) dut_wb (
    .clk(clk), .reset(reset), .cpu_strobe(a_strobe), .cpu_RW(cpu_RW),
    .uncached(uncached), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_data_in(a_cpu_data_in), .cpu_ready(a_cpu_ready),
    .mem_strobe(a_mem_strobe), .mem_RW(a_mem_RW), .mem_addr(a_mem_addr),
    .mem_data_in(a_mem_data_in), .mem_data_out(mem_data_out),
    .mem_ready(a_mem_ready), .busy(a_busy)
  );

  param_cache #(.WRITE_BACK(0)) dut_wt (
    .clk(clk), .reset(reset), .cpu_strobe(b_strobe), .cpu_RW(cpu_RW),
    .uncached(uncached), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_data_in(b_cpu_data_in), .cpu_ready(b_cpu_ready),
    .mem_strobe(b_mem_strobe), .mem_RW(b_mem_RW), .mem_addr(b_mem_addr),
    .mem_data_in(b_mem_data_in), .mem_data_out(mem_data_out),
    .mem_ready(b_mem_ready), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a CPU request at the falling edge.
  task automatic req(input logic rw, input logic unc, input logic [31:0] addr,
                     input logic [31:0] wd);
    @(negedge clk);
    cpu_strobe   = 1'b1;
    cpu_RW       = rw;
    uncached     = unc;
    cpu_addr     = addr;
    cpu_data_out = wd;
    #1;
  endtask

  // One burst beat: check the bus request, then answer it for one cycle.
  task automatic beat(input string tag, input logic [31:0] addr, input logic rw,
                      input logic [31:0] wd, input logic [31:0] rd);
    @(negedge clk);
    check({tag, "_strobe"}, mem_strobe, 32'd1);
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_rw"}, mem_RW, rw);
    if (rw) check({tag, "_wdata"}, mem_data_in, wd);
    check({tag, "_noready"}, cpu_ready, 32'd0);
    check({tag, "_busy"}, busy, 32'd1);
    mem_ready    = 1'b1;
    mem_data_out = rd;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
  endtask

  // Bypass / write-through single access; cpu_ready rises with mem_ready.
  task automatic single(input string tag, input logic [31:0] addr, input logic rw,
                        input logic [31:0] wd, input logic [31:0] rd);
    @(negedge clk);
    check({tag, "_strobe"}, mem_strobe, 32'd1);
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_rw"}, mem_RW, rw);
    if (rw) check({tag, "_wdata"}, mem_data_in, wd);
    check({tag, "_wait"}, cpu_ready, 32'd0);
    mem_ready    = 1'b1;
    mem_data_out = rd;
    #1;
    check({tag, "_ready"}, cpu_ready, 32'd1);
    if (!rw) check({tag, "_rdata"}, cpu_data_in, rd);
    @(posedge clk);
    #1;
    mem_ready  = 1'b0;
    cpu_strobe = 1'b0;
  endtask

  // The held request completes as a hit in IDLE.
  task automatic hit(input string tag, input logic [31:0] exp);
    @(negedge clk);
    check({tag, "_ready"}, cpu_ready, 32'd1);
    check({tag, "_data"}, cpu_data_in, exp);
    check({tag, "_nomem"}, mem_strobe, 32'd0);
    @(posedge clk);
    #1;
    cpu_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; sel = 1'b0; cpu_strobe = 1'b0; cpu_RW = 1'b0; uncached = 1'b0;
    cpu_addr = 32'h0; cpu_data_out = 32'h0; mem_data_out = 32'h0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_ready", cpu_ready, 32'd0);
    check("rst_strobe", mem_strobe, 32'd0);
    check("rst_rw", mem_RW, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_data_in, 32'd0);
    check("rst_rdata", cpu_data_in, 32'd0);
    check("rst_busy", busy, 32'd0);

    // Read miss with a 4-beat fill, then a same-line hit.
    req(1'b0, 1'b0, 32'h040, 32'h0);
    check("s1_miss", cpu_ready, 32'd0);
    beat("s1_f0", 32'h040, 1'b0, 32'h0, 32'h11);
    beat("s1_f1", 32'h044, 1'b0, 32'h0, 32'h22);
    beat("s1_f2", 32'h048, 1'b0, 32'h0, 32'h33);
    beat("s1_f3", 32'h04C, 1'b0, 32'h0, 32'h44);
    hit("s1_hit", 32'h11);
    req(1'b0, 1'b0, 32'h044, 32'h0);
    check("s1_hit2_ready", cpu_ready, 32'd1);
    check("s1_hit2_data", cpu_data_in, 32'h22);
    check("s1_hit2_nomem", mem_strobe, 32'd0);
    @(posedge clk); #1 cpu_strobe = 1'b0;

    // Write hit, then a conflicting read evicts the dirty line.
    req(1'b1, 1'b0, 32'h048, 32'hDEADBEEF);
    check("s2_wr_ready", cpu_ready, 32'd1);
    check("s2_wr_nomem", mem_strobe, 32'd0);
    @(posedge clk); #1 cpu_strobe = 1'b0;
    req(1'b0, 1'b0, 32'h448, 32'h0);
    check("s2_miss", cpu_ready, 32'd0);
    beat("s2_wb0", 32'h040, 1'b1, 32'h11, 32'h0);
    beat("s2_wb1", 32'h044, 1'b1, 32'h22, 32'h0);
    beat("s2_wb2", 32'h048, 1'b1, 32'hDEADBEEF, 32'h0);
    beat("s2_wb3", 32'h04C, 1'b1, 32'h44, 32'h0);
    beat("s2_f0", 32'h440, 1'b0, 32'h0, 32'h55);
    beat("s2_f1", 32'h444, 1'b0, 32'h0, 32'h66);
    beat("s2_f2", 32'h448, 1'b0, 32'h0, 32'h77);
    beat("s2_f3", 32'h44C, 1'b0, 32'h0, 32'h88);
    hit("s2_hit", 32'h77);

    // Uncached read bypasses the cache; a cached read still misses.
    req(1'b0, 1'b1, 32'h080, 32'h0);
    check("s4_unc_wait", cpu_ready, 32'd0);
    single("s4_unc", 32'h080, 1'b0, 32'h0, 32'h99);
    req(1'b0, 1'b0, 32'h080, 32'h0);
    check("s4_miss", cpu_ready, 32'd0);
    beat("s4_f0", 32'h080, 1'b0, 32'h0, 32'h1);
    beat("s4_f1", 32'h084, 1'b0, 32'h0, 32'h2);
    beat("s4_f2", 32'h088, 1'b0, 32'h0, 32'h3);
    beat("s4_f3", 32'h08C, 1'b0, 32'h0, 32'h4);
    hit("s4_hit", 32'h1);

    // Memory stalls 10 cycles on the second fill beat.
    req(1'b0, 1'b0, 32'h040, 32'h0);
    beat("s5_f0", 32'h040, 1'b0, 32'h0, 32'h11);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("s5_stall_strobe", mem_strobe, 32'd1);
      check("s5_stall_addr", mem_addr, 32'h044);
      check("s5_stall_rw", mem_RW, 32'd0);
      check("s5_stall_ready", cpu_ready, 32'd0);
      check("s5_stall_busy", busy, 32'd1);
    end
    beat("s5_f1", 32'h044, 1'b0, 32'h0, 32'h22);
    beat("s5_f2", 32'h048, 1'b0, 32'h0, 32'h33);
    beat("s5_f3", 32'h04C, 1'b0, 32'h0, 32'h44);
    hit("s5_hit", 32'h11);

    // Reset during the third fill beat abandons the burst.
    req(1'b0, 1'b0, 32'h840, 32'h0);
    beat("s6_f0", 32'h840, 1'b0, 32'h0, 32'hE0);
    beat("s6_f1", 32'h844, 1'b0, 32'h0, 32'hE1);
    @(negedge clk);
    check("s6_f2_addr", mem_addr, 32'h848);
    mem_ready = 1'b1;
    mem_data_out = 32'hE2;
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    check("s6_rst_strobe", mem_strobe, 32'd0);
    check("s6_rst_busy", busy, 32'd0);
    check("s6_rst_ready", cpu_ready, 32'd0);
    cpu_addr = 32'h040;
    #1;
    check("s6_reread_miss", cpu_ready, 32'd0);
    beat("s6_f0b", 32'h040, 1'b0, 32'h0, 32'h11);
    beat("s6_f1b", 32'h044, 1'b0, 32'h0, 32'h22);
    beat("s6_f2b", 32'h048, 1'b0, 32'h0, 32'h33);
    beat("s6_f3b", 32'h04C, 1'b0, 32'h0, 32'h44);
    hit("s6_hit", 32'h11);

    // Write-through instance: write miss does not allocate.
    @(negedge clk);
    sel = 1'b1;
    #1;
    check("s3_idle_strobe", mem_strobe, 32'd0);
    check("s3_idle_busy", busy, 32'd0);
    req(1'b1, 1'b0, 32'h100, 32'hA5A5A5A5);
    check("s3_wr_wait", cpu_ready, 32'd0);
    single("s3_wr", 32'h100, 1'b1, 32'hA5A5A5A5, 32'h0);
    req(1'b0, 1'b0, 32'h100, 32'h0);
    check("s3_rd_miss", cpu_ready, 32'd0);
    check("s3_rd_nomem_yet", mem_strobe, 32'd0);
    beat("s3_f0", 32'h100, 1'b0, 32'h0, 32'hA5A5A5A5);
    beat("s3_f1", 32'h104, 1'b0, 32'h0, 32'hB1);
    beat("s3_f2", 32'h108, 1'b0, 32'h0, 32'hB2);
    beat("s3_f3", 32'h10C, 1'b0, 32'h0, 32'hB3);
    hit("s3_hit", 32'hA5A5A5A5);
    // Write-through hit updates the resident word.
    req(1'b1, 1'b0, 32'h104, 32'h12345678);
    check("s3_wth_wait", cpu_ready, 32'd0);
    single("s3_wth", 32'h104, 1'b1, 32'h12345678, 32'h0);
    req(1'b0, 1'b0, 32'h104, 32'h0);
    check("s3_rdback_ready", cpu_ready, 32'd1);
    check("s3_rdback_data", cpu_data_in, 32'h12345678);
    check("s3_rdback_nomem", mem_strobe, 32'd0);
    @(posedge clk); #1 cpu_strobe = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
